// File: rtl/load_buffer.sv
// load_buffer: in-order load queue between the reservation station and the
// memory controller. Loads are queued in issue order, read one at a time,
// sign/zero-extended by func3 and written back to the instruction queue.
// A pipeline clear empties the queue; a read already on the bus is drained
// and its data discarded.
// Optional feature: define LB_BYPASS_EN so an enqueue into an idle, empty
// buffer raises the memory request at the same edge (zero issue latency).
module load_buffer #(
  parameter int LB_DEPTH  = 8,
  parameter int IQ_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear_flag_in,
  input  logic                 load_enable_in,
  input  logic [2:0]           func3_in,
  input  logic [31:0]          addr_in,
  input  logic [IQ_ADDR_W-1:0] pos_in_iq_in,
  output logic                 full_out,
  output logic                 mc_req_out,
  output logic [31:0]          mc_addr_out,
  output logic [2:0]           mc_len_out,
  input  logic                 mc_done_in,
  input  logic [31:0]          mc_data_in,
  output logic                 result_enable_out,
  output logic [IQ_ADDR_W-1:0] result_idx_out,
  output logic [31:0]          result_value_out
);

  localparam int PTR_W = $clog2(LB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(LB_DEPTH);
  localparam logic [CNT_W-1:0] FULL_MARK = CNT_W'(LB_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of bytes the memory controller must fetch for a load type.
  function automatic logic [2:0] len_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: len_of = 3'd1;
      3'b001, 3'b101: len_of = 3'd2;
      default:        len_of = 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend the raw read data according to the load type.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'd0, d[7:0]};
      3'b101:  extend = {16'd0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Queue bookkeeping
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // FSM and registered outputs
  state_e                 state_q;
  logic                   mc_req_q;
  logic [31:0]            mc_addr_q;
  logic [2:0]             mc_len_q;
  logic                   res_en_q;
  logic [IQ_ADDR_W-1:0]   res_idx_q;
  logic [31:0]            res_val_q;

  // Slot storage, read at the head
  logic [31:0]          slot_addr [LB_DEPTH];
  logic [2:0]           slot_f3   [LB_DEPTH];
  logic [IQ_ADDR_W-1:0] slot_idx  [LB_DEPTH];

  logic [31:0]          head_addr;
  logic [2:0]           head_f3;
  logic [IQ_ADDR_W-1:0] head_idx;

  logic        bypass_hit;
  logic [31:0] issue_addr;
  logic [2:0]  issue_f3;
  logic        start_issue;

  // A full buffer (count == depth) silently drops a further enqueue; the
  // one-slot slack in full_out keeps a well-behaved RS from ever doing so.
  assign push = load_enable_in && !clear_flag_in && (count_q != DEPTH_C);
  assign pop  = (state_q == ST_BUSY) && mc_done_in && !clear_flag_in;

  assign full_out = (count_q >= FULL_MARK);

  generate
    for (genvar gi = 0; gi < LB_DEPTH; gi++) begin : g_slot
      logic                 we;
      logic [31:0]          addr_q;
      logic [2:0]           f3_q;
      logic [IQ_ADDR_W-1:0] idx_q;

      assign we = push && (tail_q == PTR_W'(gi));

      // Capture an incoming load when this slot is the tail.
      always_ff @(posedge clk) begin
        if (rdy && we) begin
          addr_q <= addr_in;
          f3_q   <= func3_in;
          idx_q  <= pos_in_iq_in;
        end
      end

      assign slot_addr[gi] = addr_q;
      assign slot_f3[gi]   = f3_q;
      assign slot_idx[gi]  = idx_q;
    end
  endgenerate

  assign head_addr = slot_addr[head_q];
  assign head_f3   = slot_f3[head_q];
  assign head_idx  = slot_idx[head_q];

`ifdef LB_BYPASS_EN
  // An empty buffer forwards the incoming load straight to the bus; the entry
  // is still pushed so the normal pop-on-done path retires it.
  assign bypass_hit = (count_q == '0) && push;
  assign issue_addr = bypass_hit ? addr_in  : head_addr;
  assign issue_f3   = bypass_hit ? func3_in : head_f3;
`else
  assign bypass_hit = 1'b0;
  assign issue_addr = head_addr;
  assign issue_f3   = head_f3;
`endif

  assign start_issue = ((count_q != '0) || bypass_hit) && !clear_flag_in;

  // Next head/tail/count: clear wins, otherwise push and pop act independently.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_flag_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue pointer registers; rdy low freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Read sequencer with registered bus and write-back outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
      mc_len_q  <= '0;
      res_en_q  <= 1'b0;
      res_idx_q <= '0;
      res_val_q <= '0;
    end else if (!rdy) begin
      // Everything holds, but a write-back strobe must never repeat.
      res_en_q <= 1'b0;
    end else begin
      res_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_issue) begin
            mc_req_q  <= 1'b1;
            mc_addr_q <= issue_addr;
            mc_len_q  <= len_of(issue_f3);
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mc_done_in) begin
            mc_req_q <= 1'b0;
            state_q  <= ST_IDLE;
            // Data returning in the flush cycle belongs to a squashed load.
            if (!clear_flag_in) begin
              res_en_q  <= 1'b1;
              res_idx_q <= head_idx;
              res_val_q <= extend(head_f3, mc_data_in);
            end
          end else if (clear_flag_in) begin
            // The controller cannot abort, so keep requesting until it answers.
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mc_done_in) begin
            mc_req_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          mc_req_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign mc_req_out        = mc_req_q;
  assign mc_addr_out       = mc_addr_q;
  assign mc_len_out        = mc_len_q;
  assign result_enable_out = res_en_q;
  assign result_idx_out    = res_idx_q;
  assign result_value_out  = res_val_q;

endmodule
